mem_fill_arbiter: RTL and testbench
===================================

MEM_FILL_ARBITER -- requirements
Module: mem_fill_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: i_req  input  1  instruction-cache miss request; held high until i_done.
REQ-004 SHALL have port: i_addr  input  16  instruction miss byte address; stable while i_req high.
REQ-005 SHALL have port: d_req  input  1  data-cache miss request; held high until d_done.
REQ-006 SHALL have port: d_addr  input  16  data miss byte address; stable while d_req high.
REQ-007 SHALL have port: mem_en  output  1  read issue strobe to 4-cycle pipelined main memory.
REQ-008 SHALL have port: mem_addr  output  16  memory read byte address.
REQ-009 SHALL have port: mem_valid  input  1  read data valid, exactly 4 cycles after each accepted mem_en.
REQ-010 SHALL have port: fill_we  output  1  write one word into selected cache data array.
REQ-011 SHALL have port: fill_sel  output  1  target cache: 0 = instruction, 1 = data.
REQ-012 SHALL have port: fill_word  output  3  word index within 16-byte block being written.
REQ-013 SHALL have port: i_done  output  1  one-cycle pulse: instruction block fill complete.
REQ-014 SHALL have port: d_done  output  1  one-cycle pulse: data block fill complete.

Function
REQ-015 SHALL implement FSM states IDLE, FILL, DONE; reset state IDLE.
REQ-016 IDLE -> FILL when i_req or d_req high; grant latched into fill_sel at transition.
REQ-017 Both requests high in IDLE: grant side not served by the last completed fill; last_served resets to instruction, so first contention grants data.
REQ-018 Only one request high: grant it regardless of last_served.
REQ-019 No preemption: a fill in progress SHALL complete before any other grant.
REQ-020 Block base latched on grant: addr[15:4] of granted request.
REQ-021 FILL: issue counter 0..7; mem_en high for 8 consecutive cycles starting the first FILL cycle; mem_addr = {base, issue_cnt, 1'b0}.
REQ-022 Issue counter SHALL saturate at 8; mem_en low once 8 reads issued.
REQ-023 Receive counter 0..7 increments on each mem_valid in FILL; fill_we = mem_valid in FILL; fill_word = receive counter.
REQ-024 8th mem_valid SHALL move FSM to DONE; DONE lasts exactly one cycle, asserting i_done or d_done per fill_sel, updating last_served, then -> IDLE.
REQ-025 Fill latency: grant edge to done pulse = 12 cycles (8 issues, 4-cycle memory latency, +1 DONE).
REQ-026 Request re-sampled in IDLE the cycle after DONE; back-to-back fills SHALL lose no more than that one idle cycle.
REQ-027 mem_valid in IDLE or DONE SHALL be ignored (fill_we low, no counter change).
REQ-028 fill_sel and fill_word SHALL hold stable between fill_we pulses within a fill.
REQ-029 Request dropped mid-fill SHALL not abort; fill completes and done pulses.

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, counters 0, last_served = instruction, mem_en 0, mem_addr 0, fill_we 0, fill_sel 0, fill_word 0, i_done 0, d_done 0.
REQ-031 Reset mid-fill SHALL abandon the fill without done pulse; in-flight mem_valid after release SHALL be ignored per REQ-027.

Verification
REQ-032 i_req=1, i_addr=0x1236 -> mem_en 8 cycles, mem_addr 0x1230..0x123E step 2, fill_sel=0, fill_word 0..7, i_done pulse 12 cycles after grant.
REQ-033 i_req and d_req rise same cycle after reset -> data filled first (d_done), then instruction (i_done), one IDLE cycle between.
REQ-034 Both held continuously for 4 fills -> grants alternate D,I,D,I.
REQ-035 d_req raised during instruction fill -> no mem_addr change until i_done; data fill starts after.
REQ-036 rst_n low at 6th fill cycle, released 2 cycles later with requests low -> all outputs 0, late mem_valid produces no fill_we.
REQ-037 Spurious mem_valid pulses in IDLE -> fill_we stays 0, next fill fill_word starts at 0.

Source files
------------

// File: rtl/mem_fill_if.sv
// Bundles the cache-miss request side, the main-memory read port and the cache fill port.
interface mem_fill_if;
  logic        i_req;
  logic [15:0] i_addr;
  logic        d_req;
  logic [15:0] d_addr;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic        mem_valid;
  logic        fill_we;
  logic        fill_sel;
  logic [2:0]  fill_word;
  logic        i_done;
  logic        d_done;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, mem_valid,
    output mem_en, mem_addr, fill_we, fill_sel, fill_word, i_done, d_done
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, mem_valid,
    input  mem_en, mem_addr, fill_we, fill_sel, fill_word, i_done, d_done
  );
endinterface

// File: rtl/mem_fill_arbiter.sv
// Arbitrates I-cache and D-cache block misses onto one pipelined memory port and
// streams the eight returned halfwords of each 16-byte block into the granted cache.
module mem_fill_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  mem_fill_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r, state_n;
  logic [11:0] base_r, base_n;
  logic [3:0]  issue_cnt_r, issue_cnt_n;
  logic [2:0]  rx_cnt_r, rx_cnt_n;
  logic        last_served_r, last_served_n;
  logic        mem_en_r, mem_en_n;
  logic [15:0] mem_addr_r, mem_addr_n;
  logic        fill_sel_r, fill_sel_n;
  logic        i_done_r, i_done_n;
  logic        d_done_r, d_done_n;
  logic        grant_s;

  // Next-state, grant and datapath update logic
  always_comb begin
    state_n       = state_r;
    base_n        = base_r;
    issue_cnt_n   = issue_cnt_r;
    rx_cnt_n      = rx_cnt_r;
    last_served_n = last_served_r;
    mem_en_n      = 1'b0;
    mem_addr_n    = mem_addr_r;
    fill_sel_n    = fill_sel_r;
    i_done_n      = 1'b0;
    d_done_n      = 1'b0;

    // Round-robin only under contention; a lone request wins outright
    if (bus.i_req && bus.d_req) begin
      grant_s = ~last_served_r;
    end else if (bus.d_req) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end

    case (state_r)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          state_n     = FILL;
          fill_sel_n  = grant_s;
          base_n      = grant_s ? bus.d_addr[15:4] : bus.i_addr[15:4];
          mem_en_n    = 1'b1;
          mem_addr_n  = {base_n, 4'b0000};
          issue_cnt_n = 4'd1;
          rx_cnt_n    = 3'd0;
        end else begin
          state_n = IDLE;
        end
      end
      FILL: begin
        // issue_cnt_r indexes the next read to present; it parks at 8
        if (issue_cnt_r < 4'd8) begin
          mem_en_n    = 1'b1;
          mem_addr_n  = {base_r, issue_cnt_r[2:0], 1'b0};
          issue_cnt_n = issue_cnt_r + 4'd1;
        end else begin
          issue_cnt_n = issue_cnt_r;
        end
        if (bus.mem_valid) begin
          rx_cnt_n = rx_cnt_r + 3'd1;
          if (rx_cnt_r == 3'd7) begin
            state_n  = DONE;
            i_done_n = ~fill_sel_r;
            d_done_n = fill_sel_r;
          end else begin
            state_n = FILL;
          end
        end else begin
          rx_cnt_n = rx_cnt_r;
        end
      end
      DONE: begin
        state_n       = IDLE;
        last_served_n = fill_sel_r;
        issue_cnt_n   = 4'd0;
        rx_cnt_n      = 3'd0;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and registered-output update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      base_r        <= 12'd0;
      issue_cnt_r   <= 4'd0;
      rx_cnt_r      <= 3'd0;
      last_served_r <= 1'b0;
      mem_en_r      <= 1'b0;
      mem_addr_r    <= 16'd0;
      fill_sel_r    <= 1'b0;
      i_done_r      <= 1'b0;
      d_done_r      <= 1'b0;
    end else begin
      state_r       <= state_n;
      base_r        <= base_n;
      issue_cnt_r   <= issue_cnt_n;
      rx_cnt_r      <= rx_cnt_n;
      last_served_r <= last_served_n;
      mem_en_r      <= mem_en_n;
      mem_addr_r    <= mem_addr_n;
      fill_sel_r    <= fill_sel_n;
      i_done_r      <= i_done_n;
      d_done_r      <= d_done_n;
    end
  end

  // The write strobe follows returning data directly so each word lands the cycle it arrives
  assign bus.fill_we   = (state_r == FILL) && bus.mem_valid;
  assign bus.fill_word = rx_cnt_r;
  assign bus.fill_sel  = fill_sel_r;
  assign bus.mem_en    = mem_en_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.i_done    = i_done_r;
  assign bus.d_done    = d_done_r;

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter with a 4-cycle pipelined memory model.
module tb_mem_fill_arbiter;

  logic clk;
  logic rst_n;
  logic spur;
  logic [3:0] pipe = 4'b0000;
  int n_checks;
  int n_fail;

  mem_fill_if bus ();

  mem_fill_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns data exactly four cycles after each accepted read strobe
  always @(posedge clk) pipe <= {pipe[2:0], bus.mem_en};
  assign bus.mem_valid = pipe[3] | spur;

  task automatic test_reset;
    rst_n = 1'b0;
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    bus.i_addr = 16'h0000; bus.d_addr = 16'h0000;
    spur = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.mem_en !== 1'b0 || bus.mem_addr !== 16'h0000) begin
      n_fail++; $display("FAIL reset_mem: got en=%b addr=%h required 0/0000", bus.mem_en, bus.mem_addr);
    end
    n_checks++;
    if (bus.fill_we !== 1'b0 || bus.fill_sel !== 1'b0 || bus.fill_word !== 3'd0) begin
      n_fail++; $display("FAIL reset_fill: got we=%b sel=%b word=%0d required 0/0/0", bus.fill_we, bus.fill_sel, bus.fill_word);
    end
    n_checks++;
    if (bus.i_done !== 1'b0 || bus.d_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got i=%b d=%b required 0/0", bus.i_done, bus.d_done);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_instr;
    logic [15:0] exp_addr;
    bus.i_addr = 16'h1236;
    bus.i_req  = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      exp_addr = 16'h1230 + 16'((k - 1) * 2);
      n_checks++;
      if (bus.mem_en !== (k <= 8)) begin
        n_fail++; $display("FAIL single_mem_en k=%0d: got %b required %b", k, bus.mem_en, (k <= 8));
      end
      if (k <= 8) begin
        n_checks++;
        if (bus.mem_addr !== exp_addr) begin
          n_fail++; $display("FAIL single_mem_addr k=%0d: got %h required %h", k, bus.mem_addr, exp_addr);
        end
      end
      n_checks++;
      if (bus.fill_we !== (k >= 5 && k <= 12)) begin
        n_fail++; $display("FAIL single_fill_we k=%0d: got %b required %b", k, bus.fill_we, (k >= 5 && k <= 12));
      end
      if (k >= 5 && k <= 12) begin
        n_checks++;
        if (bus.fill_word !== 3'(k - 5) || bus.fill_sel !== 1'b0) begin
          n_fail++; $display("FAIL single_fill_word k=%0d: got word=%0d sel=%b required %0d/0", k, bus.fill_word, bus.fill_sel, k - 5);
        end
      end
      n_checks++;
      if (bus.i_done !== (k == 13) || bus.d_done !== 1'b0) begin
        n_fail++; $display("FAIL single_done k=%0d: got i=%b d=%b required %b/0", k, bus.i_done, bus.d_done, (k == 13));
      end
      if (k == 13) bus.i_req = 1'b0;
    end
  endtask

  task automatic test_contention;
    int n, p;
    logic sel;
    logic [15:0] base, exp_addr;
    bus.i_addr = 16'h4006;
    bus.d_addr = 16'h8ABC;
    bus.i_req  = 1'b1;
    bus.d_req  = 1'b1;
    for (int k = 1; k <= 58; k++) begin
      @(negedge clk);
      n = (k - 1) / 14;
      p = (k - 1) % 14 + 1;
      sel = (n < 4) && (n % 2 == 0);
      base = sel ? 16'h8AB0 : 16'h4000;
      exp_addr = base + 16'((p - 1) * 2);
      if (n < 4) begin
        n_checks++;
        if (bus.mem_en !== (p <= 8)) begin
          n_fail++; $display("FAIL contend_mem_en k=%0d: got %b required %b", k, bus.mem_en, (p <= 8));
        end
        if (p <= 8) begin
          n_checks++;
          if (bus.mem_addr !== exp_addr) begin
            n_fail++; $display("FAIL contend_mem_addr k=%0d: got %h required %h", k, bus.mem_addr, exp_addr);
          end
        end
        if (p <= 13) begin
          n_checks++;
          if (bus.fill_sel !== sel) begin
            n_fail++; $display("FAIL contend_sel k=%0d: got %b required %b", k, bus.fill_sel, sel);
          end
        end
        if (p >= 5 && p <= 12) begin
          n_checks++;
          if (bus.fill_we !== 1'b1 || bus.fill_word !== 3'(p - 5)) begin
            n_fail++; $display("FAIL contend_fill k=%0d: got we=%b word=%0d required 1/%0d", k, bus.fill_we, bus.fill_word, p - 5);
          end
        end
        n_checks++;
        if (bus.i_done !== (p == 13 && !sel) || bus.d_done !== (p == 13 && sel)) begin
          n_fail++; $display("FAIL contend_done k=%0d: got i=%b d=%b required %b/%b", k, bus.i_done, bus.d_done, (p == 13 && !sel), (p == 13 && sel));
        end
      end else begin
        n_checks++;
        if (bus.mem_en !== 1'b0 || bus.fill_we !== 1'b0) begin
          n_fail++; $display("FAIL contend_quiet k=%0d: got en=%b we=%b required 0/0", k, bus.mem_en, bus.fill_we);
        end
      end
      if (k == 55) begin
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
      end
    end
  endtask

  task automatic test_no_preempt;
    logic [15:0] exp_addr;
    bus.i_addr = 16'h2224;
    bus.i_req  = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      if (k <= 8) begin
        exp_addr = 16'h2220 + 16'((k - 1) * 2);
        n_checks++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== exp_addr || bus.fill_sel !== 1'b0) begin
          n_fail++; $display("FAIL nopre_i_issue k=%0d: got en=%b addr=%h sel=%b required 1/%h/0", k, bus.mem_en, bus.mem_addr, bus.fill_sel, exp_addr);
        end
      end else if (k <= 13) begin
        n_checks++;
        if (bus.mem_en !== 1'b0 || bus.mem_addr !== 16'h222E || bus.fill_sel !== 1'b0) begin
          n_fail++; $display("FAIL nopre_hold k=%0d: got en=%b addr=%h sel=%b required 0/222e/0", k, bus.mem_en, bus.mem_addr, bus.fill_sel);
        end
      end else if (k >= 15 && k <= 22) begin
        exp_addr = 16'h3330 + 16'((k - 15) * 2);
        n_checks++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== exp_addr || bus.fill_sel !== 1'b1) begin
          n_fail++; $display("FAIL nopre_d_issue k=%0d: got en=%b addr=%h sel=%b required 1/%h/1", k, bus.mem_en, bus.mem_addr, bus.fill_sel, exp_addr);
        end
      end else begin
        n_checks++;
        if (bus.mem_en !== 1'b0) begin
          n_fail++; $display("FAIL nopre_idle_en k=%0d: got %b required 0", k, bus.mem_en);
        end
      end
      n_checks++;
      if (bus.i_done !== (k == 13) || bus.d_done !== (k == 27)) begin
        n_fail++; $display("FAIL nopre_done k=%0d: got i=%b d=%b required %b/%b", k, bus.i_done, bus.d_done, (k == 13), (k == 27));
      end
      if (k == 3) begin
        bus.d_addr = 16'h3334;
        bus.d_req  = 1'b1;
      end
      if (k == 13) bus.i_req = 1'b0;
      if (k == 27) bus.d_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid_fill;
    bus.i_addr = 16'h5558;
    bus.i_req  = 1'b1;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    bus.i_req = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_en !== 1'b0 || bus.mem_addr !== 16'h0000 || bus.fill_we !== 1'b0) begin
      n_fail++; $display("FAIL midrst_mem: got en=%b addr=%h we=%b required 0/0000/0", bus.mem_en, bus.mem_addr, bus.fill_we);
    end
    n_checks++;
    if (bus.fill_sel !== 1'b0 || bus.fill_word !== 3'd0 || bus.i_done !== 1'b0 || bus.d_done !== 1'b0) begin
      n_fail++; $display("FAIL midrst_fill: got sel=%b word=%0d i=%b d=%b required 0/0/0/0", bus.fill_sel, bus.fill_word, bus.i_done, bus.d_done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 9; k <= 22; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.fill_we !== 1'b0 || bus.mem_en !== 1'b0 || bus.fill_word !== 3'd0) begin
        n_fail++; $display("FAIL midrst_late k=%0d: got we=%b en=%b word=%0d required 0/0/0", k, bus.fill_we, bus.mem_en, bus.fill_word);
      end
      n_checks++;
      if (bus.i_done !== 1'b0 || bus.d_done !== 1'b0) begin
        n_fail++; $display("FAIL midrst_done k=%0d: got i=%b d=%b required 0/0", k, bus.i_done, bus.d_done);
      end
    end
  endtask

  task automatic test_spurious_valid;
    spur = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.fill_we !== 1'b0 || bus.fill_word !== 3'd0) begin
        n_fail++; $display("FAIL spur_idle k=%0d: got we=%b word=%0d required 0/0", k, bus.fill_we, bus.fill_word);
      end
    end
    spur = 1'b0;
    bus.i_addr = 16'h666A;
    bus.i_req  = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.fill_we !== (k >= 5 && k <= 12)) begin
        n_fail++; $display("FAIL spur_we k=%0d: got %b required %b", k, bus.fill_we, (k >= 5 && k <= 12));
      end
      if (k == 5 || k == 12) begin
        n_checks++;
        if (bus.fill_word !== 3'(k - 5)) begin
          n_fail++; $display("FAIL spur_word k=%0d: got %0d required %0d", k, bus.fill_word, k - 5);
        end
      end
      if (k == 1) begin
        n_checks++;
        if (bus.mem_addr !== 16'h6660) begin
          n_fail++; $display("FAIL spur_addr: got %h required 6660", bus.mem_addr);
        end
      end
      n_checks++;
      if (bus.i_done !== (k == 13)) begin
        n_fail++; $display("FAIL spur_done k=%0d: got %b required %b", k, bus.i_done, (k == 13));
      end
      if (k == 13) bus.i_req = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset;
    test_single_instr;
    test_reset;
    test_contention;
    test_no_preempt;
    test_reset_mid_fill;
    test_spurious_valid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
